// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor.
// Derives an RTC tick from clk_freq/rtc_freq, keeps a 64-bit mtime and per-hart
// msip/mtimecmp registers, and drives per-hart software (msip) and timer (mtip)
// interrupt lines. Accessed over a simple single-cycle memory bus.
//
// Optional feature: define CLINT_MH_STOP_EN to add the stop_count input, which
// freezes the divider and mtime (bus writes to mtime still land).
//
// Ports:
//   clock, reset          core clock, synchronous active-high reset
//   stop_count            (CLINT_MH_STOP_EN only) hold divider and mtime
//   mem_valid             single-cycle request strobe
//   mem_addr[31:0]        byte address, bits [1:0] ignored
//   mem_wdata[31:0]       write data
//   mem_wstrb[3:0]        byte write enables, 0 = read
//   mem_ready             response strobe, one cycle after the request
//   mem_rdata[31:0]       read data, valid only while mem_ready=1, else 0
//   mtime[63:0]           current mtime
//   msip[num_harts-1:0]   software interrupt per hart
//   mtip[num_harts-1:0]   timer interrupt per hart
//
// Address map (offset from base_addr):
//   0x0000 + 4*h   msip[h] (bit 0)
//   0x4000 + 8*h   mtimecmp[h] low word, +4 high word
//   0xBFF8/0xBFFC  mtime low/high word
//   anything else in the 64 KiB window reads 0, ignores writes, still acks.

module clint_mh #(
    parameter int unsigned num_harts = 1,
    parameter int unsigned clk_freq  = 1000000000,
    parameter int unsigned rtc_freq  = 100000000,
    parameter logic [31:0] base_addr = 32'h0200_0000
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef CLINT_MH_STOP_EN
    input  logic                 stop_count,
`endif
    input  logic                 mem_valid,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    output logic [63:0]          mtime,
    output logic [num_harts-1:0] msip,
    output logic [num_harts-1:0] mtip
);

    localparam int unsigned DIV      = clk_freq / rtc_freq;
    // DIV<=1 collapses to a counter pinned at 0 that ticks every cycle.
    localparam logic [31:0] DIV_LAST = (DIV <= 1) ? 32'd0 : 32'(DIV - 1);

    localparam logic [13:0] MTIME_LO_WORD = 14'h2FFE;  // 0xBFF8 >> 2
    localparam logic [13:0] MTIME_HI_WORD = 14'h2FFF;  // 0xBFFC >> 2

    // State
    logic [31:0]          div_cnt_q, div_cnt_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q [num_harts];
    logic [63:0]          mtimecmp_d [num_harts];
    logic [num_harts-1:0] msip_q, msip_d;
    logic [num_harts-1:0] mtip_q, mtip_d;
    logic                 ready_q, ready_d;
    logic [31:0]          rdata_q, rdata_d;

    // Combinational helpers
    logic        run_c;
    logic        tick_c;
    logic [29:0] word_off_c;
    logic        in_win_c;
    logic [11:0] msip_hart_c;
    logic [10:0] cmp_hart_c;
    logic        sel_msip_c;
    logic        sel_cmp_c;
    logic        sel_mtime_lo_c;
    logic        sel_mtime_hi_c;
    logic        wr_c;
    logic [31:0] rsel_c;
    logic        unused_addr_c;

    assign unused_addr_c = ^mem_addr[1:0];

`ifdef CLINT_MH_STOP_EN
    assign run_c = ~stop_count;
`else
    assign run_c = 1'b1;
`endif

    // Merge a 32-bit write into an existing word, one byte lane per strobe bit.
    function automatic logic [31:0] merge_w(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // RTC divider: tick in the cycle the counter sits at DIV-1, then wrap.
    always_comb begin
        div_cnt_d = div_cnt_q;
        tick_c    = 1'b0;
        if (run_c) begin
            if (div_cnt_q == DIV_LAST) begin
                tick_c    = 1'b1;
                div_cnt_d = 32'd0;
            end else begin
                div_cnt_d = div_cnt_q + 32'd1;
            end
        end
    end

    // Address decode, word granular and relative to base_addr.
    always_comb begin
        word_off_c     = mem_addr[31:2] - base_addr[31:2];
        in_win_c       = (word_off_c[29:14] == 16'd0);
        msip_hart_c    = word_off_c[11:0];
        cmp_hart_c     = word_off_c[11:1];
        sel_msip_c     = in_win_c && (word_off_c[13:12] == 2'b00)
                         && (32'(msip_hart_c) < num_harts);
        sel_cmp_c      = in_win_c && (word_off_c[13:12] == 2'b01)
                         && (32'(cmp_hart_c) < num_harts);
        sel_mtime_lo_c = in_win_c && (word_off_c[13:0] == MTIME_LO_WORD);
        sel_mtime_hi_c = in_win_c && (word_off_c[13:0] == MTIME_HI_WORD);
        wr_c           = mem_valid && (mem_wstrb != 4'b0000);
    end

    // Next state for mtime, mtimecmp, msip and mtip. A write overrides only
    // its own byte lanes on top of the already-incremented mtime.
    always_comb begin
        mtime_d = tick_c ? (mtime_q + 64'd1) : mtime_q;
        if (wr_c && sel_mtime_lo_c) begin
            mtime_d[31:0] = merge_w(mtime_d[31:0], mem_wdata, mem_wstrb);
        end
        if (wr_c && sel_mtime_hi_c) begin
            mtime_d[63:32] = merge_w(mtime_d[63:32], mem_wdata, mem_wstrb);
        end

        msip_d = msip_q;
        mtip_d = mtip_q;
        for (int unsigned h = 0; h < num_harts; h++) begin
            mtimecmp_d[h] = mtimecmp_q[h];
            if (wr_c && sel_msip_c && (msip_hart_c == 12'(h)) && mem_wstrb[0]) begin
                msip_d[h] = mem_wdata[0];
            end
            if (wr_c && sel_cmp_c && (cmp_hart_c == 11'(h))) begin
                if (word_off_c[0]) begin
                    mtimecmp_d[h][63:32] = merge_w(mtimecmp_q[h][63:32], mem_wdata, mem_wstrb);
                end else begin
                    mtimecmp_d[h][31:0]  = merge_w(mtimecmp_q[h][31:0], mem_wdata, mem_wstrb);
                end
            end
            mtip_d[h] = (mtime_d >= mtimecmp_d[h]);
        end
    end

    // Read mux on pre-edge state; response lands one cycle later.
    always_comb begin
        rsel_c = 32'd0;
        for (int unsigned h = 0; h < num_harts; h++) begin
            if (sel_msip_c && (msip_hart_c == 12'(h))) begin
                rsel_c = {31'd0, msip_q[h]};
            end
            if (sel_cmp_c && (cmp_hart_c == 11'(h))) begin
                rsel_c = word_off_c[0] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
            end
        end
        if (sel_mtime_lo_c) begin
            rsel_c = mtime_q[31:0];
        end
        if (sel_mtime_hi_c) begin
            rsel_c = mtime_q[63:32];
        end
        ready_d = mem_valid;
        rdata_d = mem_valid ? rsel_c : 32'd0;
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= 32'd0;
            mtime_q   <= 64'd0;
            msip_q    <= '0;
            mtip_q    <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'd0;
            for (int unsigned h = 0; h < num_harts; h++) begin
                mtimecmp_q[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else begin
            div_cnt_q <= div_cnt_d;
            mtime_q   <= mtime_d;
            msip_q    <= msip_d;
            mtip_q    <= mtip_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            for (int unsigned h = 0; h < num_harts; h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign mtime     = mtime_q;
    assign msip      = msip_q;
    assign mtip      = mtip_q;

endmodule

// File: tb/tb_clint_mh.sv
// Directed bench for clint_mh: two harts, default clocks (divide by 10).
module tb_clint_mh;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clock;
    logic        reset;
`ifdef CLINT_MH_STOP_EN
    logic        stop_count;
`endif
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [63:0] mtime;
    logic [1:0]  msip;
    logic [1:0]  mtip;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rd;
    logic        rdy;
    logic        prev_mtip;
    logic        found;

    clint_mh #(
        .num_harts(2),
        .clk_freq (1000000000),
        .rtc_freq (100000000),
        .base_addr(BASE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef CLINT_MH_STOP_EN
        .stop_count(stop_count),
`endif
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mtime     (mtime),
        .msip      (msip),
        .mtip      (mtip)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One bus request; returns the response sampled in the following cycle.
    task automatic bus_op(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb,
                          output logic [31:0] rdata_o, output logic ready_o);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        @(posedge clock);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        rdata_o   = mem_rdata;
        ready_o   = mem_ready;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'b0000;
`ifdef CLINT_MH_STOP_EN
        stop_count = 1'b0;
`endif
        step(3);
        reset = 1'b0;

        // Reset state
        check("rst_mtime", mtime, 64'd0);
        check("rst_msip", 64'(msip), 64'd0);
        check("rst_mtip", 64'(mtip), 64'd0);
        check("rst_ready", 64'(mem_ready), 64'd0);
        check("rst_rdata", 64'(mem_rdata), 64'd0);

        // Divide-by-10 tick: 99 edges -> 9 ticks, 100 edges -> 10
        step(99);
        check("idle_99", mtime, 64'd9);
        step(1);
        check("idle_100", mtime, 64'd10);
        check("idle_mtip", 64'(mtip), 64'd0);
        check("idle_msip", 64'(msip), 64'd0);

        // msip for hart 1
        bus_op(BASE + 32'h4, 32'd1, 4'hF, rd, rdy);
        check("msip_wr_ready", 64'(rdy), 64'd1);
        check("msip_out", 64'(msip), 64'd2);
        bus_op(BASE + 32'h4, 32'd0, 4'h0, rd, rdy);
        check("msip_rd_data", 64'(rd), 64'd1);
        step(1);
        check("ready_drop", 64'(mem_ready), 64'd0);
        check("rdata_drop", 64'(mem_rdata), 64'd0);

        // mtimecmp[0] = 20
        bus_op(BASE + 32'h4004, 32'd0, 4'hF, rd, rdy);
        bus_op(BASE + 32'h4000, 32'd20, 4'hF, rd, rdy);
        bus_op(BASE + 32'h4000, 32'd0, 4'h0, rd, rdy);
        check("cmp0_lo_rd", 64'(rd), 64'd20);
        check("cmp_pre_mtip", 64'(mtip), 64'd0);
        found     = 1'b0;
        prev_mtip = mtip[0];
        for (int i = 0; i < 200; i++) begin
            prev_mtip = mtip[0];
            step(1);
            if (mtime == 64'd20) begin
                found = 1'b1;
                break;
            end
        end
        check("cmp_reach20", 64'(found), 64'd1);
        check("mtip_before", 64'(prev_mtip), 64'd0);
        check("mtip_rise", 64'(mtip[0]), 64'd1);
        bus_op(BASE + 32'h4000, 32'd100, 4'hF, rd, rdy);
        check("mtip_fall", 64'(mtip[0]), 64'd0);

        // mtime rollover of the low word into the high word
        bus_op(BASE + 32'hBFFC, 32'd0, 4'hF, rd, rdy);
        bus_op(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        check("mtime_wr", mtime, 64'h0000_0000_FFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (mtime != 64'h0000_0000_FFFF_FFFF) begin
                found = 1'b1;
                break;
            end
        end
        check("mtime_tick_seen", 64'(found), 64'd1);
        check("mtime_carry", mtime, 64'h0000_0001_0000_0000);
        check("mtip_big", 64'(mtip), 64'd1);

        // Byte write on a tick edge: lane 0 written, lanes 1..7 from mtime+1
        bus_op(BASE + 32'hBFF8, 32'h0000_00FF, 4'hF, rd, rdy);
        check("mtime_ff", mtime, 64'h0000_0001_0000_00FF);
        step(8);
        bus_op(BASE + 32'hBFF8, 32'h0000_0055, 4'b0001, rd, rdy);
        check("tick_wr_merge", mtime, 64'h0000_0001_0000_0155);

        // Unmapped offsets and out-of-range harts
        bus_op(BASE + 32'h8000, 32'd0, 4'h0, rd, rdy);
        check("oor_rd_ready", 64'(rdy), 64'd1);
        check("oor_rd_data", 64'(rd), 64'd0);
        bus_op(BASE + 32'h14, 32'd0, 4'h0, rd, rdy);
        check("hart5_rd_data", 64'(rd), 64'd0);
        check("hart5_rd_ready", 64'(rdy), 64'd1);
        bus_op(BASE + 32'h14, 32'd0, 4'hF, rd, rdy);
        bus_op(BASE + 32'h8, 32'd1, 4'hF, rd, rdy);
        bus_op(BASE + 32'h4028, 32'd0, 4'hF, rd, rdy);
        bus_op(BASE + 32'h8000, 32'h1234_5678, 4'hF, rd, rdy);
        check("oor_wr_ready", 64'(rdy), 64'd1);
        check("oor_msip", 64'(msip), 64'd2);
        bus_op(BASE + 32'h4008, 32'd0, 4'h0, rd, rdy);
        check("oor_cmp1_lo", 64'(rd), 64'hFFFF_FFFF);
        bus_op(BASE + 32'h4000, 32'd0, 4'h0, rd, rdy);
        check("oor_cmp0_lo", 64'(rd), 64'd100);
        bus_op(BASE + 32'h0, 32'd0, 4'h0, rd, rdy);
        check("msip0_rd", 64'(rd), 64'd0);

        // Reset while a request is in flight
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h4;
        mem_wstrb = 4'h0;
        reset     = 1'b1;
        step(1);
        mem_valid = 1'b0;
        reset     = 1'b0;
        check("rst_mid_ready", 64'(mem_ready), 64'd0);
        check("rst_mid_rdata", 64'(mem_rdata), 64'd0);
        check("rst_mid_mtime", mtime, 64'd0);
        check("rst_mid_msip", 64'(msip), 64'd0);

`ifdef CLINT_MH_STOP_EN
        // Freeze mid-period, then resume from the held divider count
        step(10);
        check("stop_first_tick", mtime, 64'd1);
        step(3);
        stop_count = 1'b1;
        step(50);
        check("stop_hold", mtime, 64'd1);
        stop_count = 1'b0;
        step(6);
        check("stop_resume_pre", mtime, 64'd1);
        step(1);
        check("stop_resume_tick", mtime, 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
- Parametrised multi-hart core-local interruptor; successor to the fixed single-hart CLINT.
- Derives the RTC tick from clock and RTC frequency parameters, maintains a 64-bit mtime, and holds per-hart msip and mtimecmp registers.
- Drives per-hart software (msip) and timer (mtip) interrupt lines.
- Sits on the data memory bus, decoded inside the CLINT address window.

Parameters:
- num_harts, 1, number of harts; 1..16.
- clk_freq, 1000000000, core clock frequency in Hz.
- rtc_freq, 100000000, mtime tick frequency in Hz.
- base_addr, 32'h2000000, base of the CLINT window.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous reset, active-high.
- mem_valid  in  1  request strobe, single cycle.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write enables; 0 means read.
- mem_ready  out  1  response strobe.
- mem_rdata  out  32  read data.
- mtime  out  64  current mtime.
- msip  out  num_harts  software interrupt per hart.
- mtip  out  num_harts  timer interrupt per hart.

Behaviour:
- Reset values:
  - mtime=0, mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0.
  - mem_ready=0, mem_rdata=0.
  - Divider counter=0.
- Divider:
  - div = clk_freq/rtc_freq (integer division).
  - If div<=1, tick asserts every cycle.
  - Otherwise an 32-bit counter counts 0..div-1. tick asserts in the cycle the counter equals div-1, and the counter then wraps to 0.
- mtime increments by 1 on tick; it wraps from 2^64-1 to 0.
- Address map (offset from base_addr, word aligned):
  - 0x0000+4h: msip[h]; bit0 only, upper bits read 0.
  - 0x4000+8h: mtimecmp[h] low word; +4: high word.
  - 0xBFF8: mtime low word; 0xBFFC: mtime high word.
  - Offsets outside these, or hart index >= num_harts: reads return 0, writes are ignored, and the access is still acknowledged.
- Handshake:
  - A request in cycle N gives mem_ready=1 in cycle N+1 for exactly one cycle.
  - mem_rdata is valid only in that cycle and is 0 otherwise.
  - A new request is accepted every cycle, so back-to-back accesses are supported.
- Writes:
  - Applied at the clock edge ending cycle N, per byte lane by mem_wstrb.
  - msip takes bit0 only when wstrb[0]=1.
- Simultaneous tick and mtime write in the same cycle:
  - The write wins for the written bytes.
  - Unwritten bytes take the incremented value (mtime+1), computed on the full 64 bits before lane merge.
- Read data is sampled at cycle N and reflects the value before any same-cycle write or tick.
- mtip[h]:
  - Registered: mtip[h] <= (mtime_next >= mtimecmp_next[h]), unsigned 64-bit compare, where the _next values include the same-cycle write/tick.
  - mtip therefore reflects the state after each edge with no extra lag.
- msip output: msip[h] is driven directly from the register.
- Reset asserted mid-access: the pending mem_ready is dropped (0 the next cycle) and all state returns to reset values.

Optional Feature:
- Macro CLINT_MH_STOP_EN.
- Defined:
  - Adds input port stop_count (1 bit).
  - While stop_count=1, the divider counter and mtime hold and tick is suppressed.
  - Bus writes to mtime still take effect.
  - Counting resumes from the held divider value when stop_count returns to 0.
- Undefined: no stop_count port; counting is unconditional.

Test Plan:
- Reset, then idle for 100 cycles with defaults (div=10) -> mtime=10; tick every 10th cycle; mtip=0, msip=0.
- num_harts=2: write 1 to base+0x4, then read base+0x4 -> msip=2'b10; rdata=1 in the cycle after the read request.
- Write mtimecmp[0]=20 (low word=20, high word=0), then wait -> mtip[0] rises on the edge where mtime becomes 20. Write the low word to 100 -> mtip[0] falls one edge later.
- Write mtime low word=0xFFFFFFFF and high word=0, then wait one tick -> mtime=64'h1_0000_0000. Write with wstrb=4'b0001 on a tick cycle -> byte0 takes the written value and bytes 1..7 take the incremented value.
- Read base+0x8000 and hart index 5 with num_harts=2 -> rdata=0, mem_ready=1; write to the same addresses -> no state change.
- With CLINT_MH_STOP_EN defined: hold stop_count=1 for 50 cycles -> mtime unchanged. Release -> the next tick arrives after the remaining divider count.
